// File: rtl/xrnic_rq_cidb_sched.sv
// RQ consumer-index doorbell scheduler: coalesces one pending CI per QP and
// drains pending QPs round-robin onto the single CIDB register write port.
module xrnic_rq_cidb_sched #(
  parameter int unsigned NUM_QP      = 8,
  parameter int unsigned QPN_W       = 4,
  parameter logic [31:0] CIDB_BASE   = 32'h0002_0234,
  parameter logic [31:0] CIDB_STRIDE = 32'h0000_0100
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                rx_pkt_hndler_o_rq_db_data_valid,
  input  logic [31:0]         rx_pkt_hndler_o_rq_db_data,
  input  logic [9:0]          rx_pkt_hndler_o_rq_db_addr,
  output logic                rx_pkt_hndler_i_rq_db_rdy,
  output logic [15:0]         qp_rq_cidb_hndshk,
  output logic [31:0]         qp_rq_cidb_wr_addr_hndshk,
  output logic                qp_rq_cidb_wr_valid_hndshk,
  input  logic                qp_rq_cidb_wr_rdy,
  output logic                rx_MR_tvalid,
  output logic [QPN_W-1:0]    rx_MR_QPn,
  output logic [NUM_QP-1:0]   cidb_pend_mask,
  output logic [15:0]         cidb_drop_cnt,
  output logic [15:0]         cidb_coalesce_cnt
);

  localparam int unsigned IDX_W = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;
  localparam int unsigned CI_W  = 16;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    rdy_q;
  logic [NUM_QP-1:0]       pend_q, pend_d;
  logic [CI_W-1:0]         ci_q [NUM_QP];
  logic [IDX_W-1:0]        rr_q;
  logic [IDX_W-1:0]        cur_q;
  logic                    wr_valid_q;
  logic [31:0]             wr_addr_q;
  logic [CI_W-1:0]         wr_data_q;
  logic                    mr_valid_q;
  logic [QPN_W-1:0]        mr_qpn_q;
  logic [15:0]             drop_q;
  logic [15:0]             coal_q;

  logic                    acc_c;
  logic [QPN_W-1:0]        acc_qpn_c;
  logic                    acc_ok_c;
  logic [IDX_W-1:0]        acc_idx_c;
  logic                    gnt_found_c;
  logic [IDX_W-1:0]        gnt_idx_c;
  logic                    grant_c;
  logic                    done_c;
  logic                    coal_hit_c;
  logic                    unused_bits_c;

  assign unused_bits_c = ^{rx_pkt_hndler_o_rq_db_data[31:CI_W],
                           rx_pkt_hndler_o_rq_db_addr[9:QPN_W]};

  // Doorbell decode: QPN 0 and QPNs above NUM_QP are dropped
  assign acc_c     = rx_pkt_hndler_o_rq_db_data_valid & rdy_q;
  assign acc_qpn_c = rx_pkt_hndler_o_rq_db_addr[QPN_W-1:0];
  assign acc_ok_c  = acc_c && (acc_qpn_c != '0) && (32'(acc_qpn_c) <= NUM_QP);
  assign acc_idx_c = IDX_W'(acc_qpn_c - 1'b1);

  // Round-robin search starting just after the last completed QP
  always_comb begin : grant_search
    int unsigned k;
    k           = 0;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned i = 0; i < NUM_QP; i++) begin
      k = (32'(rr_q) + 32'd1 + i) % NUM_QP;
      if (!gnt_found_c && pend_q[IDX_W'(k)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found_c)       state_d = S_WAIT;
      S_WAIT:  if (qp_rq_cidb_wr_rdy) state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE:  grant_c = gnt_found_c;
      S_WAIT:  done_c  = qp_rq_cidb_wr_rdy;
      default: ;
    endcase
  end

  // A same-cycle accept wins the pend bit over the grant that clears it
  always_comb begin
    pend_d = pend_q;
    if (grant_c)  pend_d[gnt_idx_c] = 1'b0;
    if (acc_ok_c) pend_d[acc_idx_c] = 1'b1;
    coal_hit_c = acc_ok_c && pend_q[acc_idx_c] && !(grant_c && (gnt_idx_c == acc_idx_c));
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rdy_q      <= 1'b0;
      pend_q     <= '0;
      rr_q       <= IDX_W'(NUM_QP - 1);
      cur_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      mr_valid_q <= 1'b0;
      mr_qpn_q   <= '0;
      drop_q     <= '0;
      coal_q     <= '0;
      for (int unsigned i = 0; i < NUM_QP; i++) ci_q[i] <= '0;
    end else begin
      rdy_q  <= 1'b1;
      pend_q <= pend_d;
      if (acc_ok_c) ci_q[acc_idx_c] <= rx_pkt_hndler_o_rq_db_data[CI_W-1:0];
      if (grant_c) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= CIDB_BASE + CIDB_STRIDE * 32'(gnt_idx_c);
        wr_data_q  <= ci_q[gnt_idx_c];
        cur_q      <= gnt_idx_c;
      end else if (done_c) begin
        wr_valid_q <= 1'b0;
        rr_q       <= cur_q;
      end
      mr_valid_q <= acc_ok_c;
      if (acc_ok_c) mr_qpn_q <= acc_qpn_c;
      if (acc_c && !acc_ok_c && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (coal_hit_c && (coal_q != 16'hFFFF))         coal_q <= coal_q + 16'd1;
    end
  end

  assign rx_pkt_hndler_i_rq_db_rdy  = rdy_q;
  assign qp_rq_cidb_hndshk          = wr_data_q;
  assign qp_rq_cidb_wr_addr_hndshk  = wr_addr_q;
  assign qp_rq_cidb_wr_valid_hndshk = wr_valid_q;
  assign rx_MR_tvalid               = mr_valid_q;
  assign rx_MR_QPn                  = mr_qpn_q;
  assign cidb_pend_mask             = pend_q;
  assign cidb_drop_cnt              = drop_q;
  assign cidb_coalesce_cnt          = coal_q;

endmodule

// File: tb/tb_xrnic_rq_cidb_sched.sv
// Bench for xrnic_rq_cidb_sched: directed scenarios plus a randomized run
// compared cycle by cycle against a per-QP pending-table reference model.
module tb_xrnic_rq_cidb_sched;

  localparam int NUM_QP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        db_v = 1'b0;
  logic [31:0] db_data = '0;
  logic [9:0]  db_addr = '0;
  logic        db_rdy;
  logic [15:0] wr_data;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic        wr_rdy = 1'b0;
  logic        mr_tvalid;
  logic [3:0]  mr_qpn;
  logic [7:0]  pend_mask;
  logic [15:0] drop_cnt;
  logic [15:0] coal_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  logic [31:0] obs_addr[$];
  logic [15:0] obs_data[$];

  // Reference model: pending CI table, one in-flight write, last-served QP
  bit          m_pend [0:NUM_QP];
  logic [15:0] m_ci   [0:NUM_QP];
  int          m_busy, m_cur, m_last, m_drop, m_coal, m_mr, m_mrq, m_rdy;
  logic [31:0] m_addr;
  logic [15:0] m_data;

  xrnic_rq_cidb_sched dut (
    .core_clk                         (clk),
    .core_rst                         (rst),
    .rx_pkt_hndler_o_rq_db_data_valid (db_v),
    .rx_pkt_hndler_o_rq_db_data       (db_data),
    .rx_pkt_hndler_o_rq_db_addr       (db_addr),
    .rx_pkt_hndler_i_rq_db_rdy        (db_rdy),
    .qp_rq_cidb_hndshk                (wr_data),
    .qp_rq_cidb_wr_addr_hndshk        (wr_addr),
    .qp_rq_cidb_wr_valid_hndshk       (wr_valid),
    .qp_rq_cidb_wr_rdy                (wr_rdy),
    .rx_MR_tvalid                     (mr_tvalid),
    .rx_MR_QPn                        (mr_qpn),
    .cidb_pend_mask                   (pend_mask),
    .cidb_drop_cnt                    (drop_cnt),
    .cidb_coalesce_cnt                (coal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_step(input logic r, input logic v, input logic [9:0] a,
                                     input logic [31:0] d, input logic wr);
    int q, c, g;
    if (r) begin
      for (int i = 0; i <= NUM_QP; i++) begin m_pend[i] = 0; m_ci[i] = '0; end
      m_busy = 0; m_cur = 0; m_last = NUM_QP; m_addr = '0; m_data = '0;
      m_drop = 0; m_coal = 0; m_mr = 0; m_mrq = 0; m_rdy = 0;
      return;
    end
    g = 0;
    if (m_busy != 0) begin
      if (wr) begin m_busy = 0; m_last = m_cur; end
    end else begin
      for (int i = 1; i <= NUM_QP; i++) begin
        c = ((m_last + i - 1) % NUM_QP) + 1;
        if (g == 0 && m_pend[c]) g = c;
      end
    end
    if (g != 0) begin
      m_busy = 1; m_cur = g; m_pend[g] = 0; m_data = m_ci[g];
      m_addr = 32'h0002_0234 + 32'h0000_0100 * 32'(g - 1);
    end
    m_mr = 0;
    if (v && m_rdy != 0) begin
      q = int'(a[3:0]);
      if (q >= 1 && q <= NUM_QP) begin
        if (m_pend[q] && m_coal < 65535) m_coal++;
        m_pend[q] = 1; m_ci[q] = d[15:0]; m_mr = 1; m_mrq = q;
      end else if (m_drop < 65535) m_drop++;
    end
    m_rdy = 1;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 1; i <= NUM_QP; i++) m[i-1] = m_pend[i];
    return m;
  endfunction

  // Advance one clock; inputs are captured before the edge, outputs settle by return
  task automatic tick();
    logic s_r, s_v, s_w;
    logic [9:0] s_a;
    logic [31:0] s_d;
    s_r = rst; s_v = db_v; s_w = wr_rdy; s_a = db_addr; s_d = db_data;
    if (wr_valid && wr_rdy && !rst) begin
      xfer_cnt++;
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end
    @(posedge clk);
    model_step(s_r, s_v, s_a, s_d, s_w);
    #1;
  endtask

  task automatic send(input int q, input logic [15:0] ci);
    db_v = 1'b1; db_addr = 10'(q); db_data = {16'hA5A5, ci};
    tick();
    db_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; db_v = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; db_v = 1'b0; wr_rdy = 1'b0;
    repeat (3) tick();
    n_cmp++; if (db_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %0b want 0", db_rdy); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", wr_valid); end
    n_cmp++; if ({wr_addr, wr_data} !== 48'h0) begin n_fail++; $display("FAIL reset_addr_data got %h/%h want 0", wr_addr, wr_data); end
    n_cmp++; if ({mr_tvalid, mr_qpn} !== 5'h0) begin n_fail++; $display("FAIL reset_mr got %0b/%0d want 0", mr_tvalid, mr_qpn); end
    n_cmp++; if ({pend_mask, drop_cnt, coal_cnt} !== 40'h0) begin n_fail++; $display("FAIL reset_status got %h/%h/%h want 0", pend_mask, drop_cnt, coal_cnt); end
    rst = 1'b0;
    tick();
    n_cmp++; if (db_rdy !== 1'b1) begin n_fail++; $display("FAIL release_rdy got %0b want 1", db_rdy); end
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_single();
    int n0;
    wr_rdy = 1'b1; n0 = xfer_cnt;
    send(1, 16'h0005);
    n_cmp++; if ({mr_tvalid, mr_qpn} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL single_mr got %0b/%0d want 1/1", mr_tvalid, mr_qpn); end
    n_cmp++; if (pend_mask !== 8'h01) begin n_fail++; $display("FAIL single_pend got %h want 01", pend_mask); end
    tick();
    n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 32'h0002_0234, 16'h0005}) begin n_fail++; $display("FAIL single_write got %0b/%h/%h want 1/00020234/0005", wr_valid, wr_addr, wr_data); end
    n_cmp++; if ({mr_tvalid, mr_qpn} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL single_mr_pulse got %0b/%0d want 0/1", mr_tvalid, mr_qpn); end
    repeat (5) tick();
    n_cmp++; if (xfer_cnt - n0 !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", xfer_cnt - n0); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %0b want 0", wr_valid); end
  endtask

  task automatic test_coalesce();
    do_reset();
    wr_rdy = 1'b0;
    send(1, 16'h0001);
    tick();
    send(3, 16'h0010);
    send(3, 16'h0011);
    n_cmp++; if (coal_cnt !== 16'd1) begin n_fail++; $display("FAIL coal_cnt got %0d want 1", coal_cnt); end
    n_cmp++; if (pend_mask !== 8'h04) begin n_fail++; $display("FAIL coal_pend got %h want 04", pend_mask); end
    wr_rdy = 1'b1;
    repeat (8) tick();
    n_cmp++; if (obs_addr.size() !== 2) begin n_fail++; $display("FAIL coal_writes got %0d want 2", obs_addr.size()); end
    else begin
      n_cmp++; if ({obs_addr[1], obs_data[1]} !== {32'h0002_0434, 16'h0011}) begin n_fail++; $display("FAIL coal_write got %h/%h want 00020434/0011", obs_addr[1], obs_data[1]); end
    end
  endtask

  task automatic test_rr_order();
    logic [31:0] ea [3];
    logic [15:0] ed [3];
    ea = '{32'h0002_0334, 32'h0002_0634, 32'h0002_0934};
    ed = '{16'h0022, 16'h0055, 16'h0088};
    do_reset();
    wr_rdy = 1'b1;
    send(2, 16'h0022);
    send(5, 16'h0055);
    send(8, 16'h0088);
    repeat (12) tick();
    n_cmp++; if (obs_addr.size() !== 3) begin n_fail++; $display("FAIL rr_count got %0d want 3", obs_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({obs_addr[i], obs_data[i]} !== {ea[i], ed[i]}) begin n_fail++; $display("FAIL rr_write%0d got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], ea[i], ed[i]); end
    end
  endtask

  task automatic test_stall();
    int n0, waited;
    do_reset();
    wr_rdy = 1'b0; n0 = xfer_cnt; waited = 0;
    send(4, 16'hABCD);
    while (!wr_valid && waited < 10) begin tick(); waited++; end
    n_cmp++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_grant got %0b want 1 (timeout)", wr_valid); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 32'h0002_0534, 16'hABCD}) begin n_fail++; $display("FAIL stall_hold%0d got %0b/%h/%h want 1/00020534/abcd", i, wr_valid, wr_addr, wr_data); end
    end
    n_cmp++; if (xfer_cnt !== n0) begin n_fail++; $display("FAIL stall_noxfer got %0d want 0", xfer_cnt - n0); end
    wr_rdy = 1'b1;
    tick();
    wr_rdy = 1'b0;
    repeat (5) tick();
    n_cmp++; if (xfer_cnt - n0 !== 1) begin n_fail++; $display("FAIL stall_count got %0d want 1", xfer_cnt - n0); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got %0b want 0", wr_valid); end
  endtask

  task automatic test_drop();
    int n0;
    do_reset();
    wr_rdy = 1'b1; n0 = xfer_cnt;
    send(0, 16'h1234);
    n_cmp++; if (mr_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_q0_mr got %0b want 0", mr_tvalid); end
    send(9, 16'h5678);
    n_cmp++; if (mr_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_q9_mr got %0b want 0", mr_tvalid); end
    repeat (4) tick();
    n_cmp++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
    n_cmp++; if ({xfer_cnt - n0, pend_mask} !== {32'd0, 8'h00}) begin n_fail++; $display("FAIL drop_nowrite got %0d/%h want 0/00", xfer_cnt - n0, pend_mask); end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    wr_rdy = 1'b0;
    send(5, 16'h0050);
    tick();
    send(0, 16'h0000);
    for (int q = 1; q <= 4; q++) send(q, 16'(q));
    send(1, 16'h0101);
    n_cmp++; if ({wr_valid, pend_mask, coal_cnt, drop_cnt} !== {1'b1, 8'h0F, 16'd1, 16'd1}) begin n_fail++; $display("FAIL mid_setup got %0b/%h/%0d/%0d want 1/0f/1/1", wr_valid, pend_mask, coal_cnt, drop_cnt); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({wr_valid, pend_mask, coal_cnt, drop_cnt} !== 41'h0) begin n_fail++; $display("FAIL mid_reset got %0b/%h/%0d/%0d want 0", wr_valid, pend_mask, coal_cnt, drop_cnt); end
    rst = 1'b0; wr_rdy = 1'b1; n0 = xfer_cnt;
    repeat (10) tick();
    n_cmp++; if ({xfer_cnt - n0, wr_valid} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL mid_nowrite got %0d/%0b want 0/0", xfer_cnt - n0, wr_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst    = ($urandom_range(0, 799) == 0);
      db_v   = ($urandom_range(0, 2) != 0);
      db_addr = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 10));
      db_data = $urandom;
      wr_rdy = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++; if (db_rdy !== 1'(m_rdy)) begin n_fail++; $display("FAIL rnd_rdy c%0d got %0b want %0d", cyc, db_rdy, m_rdy); end
      n_cmp++; if (wr_valid !== 1'(m_busy)) begin n_fail++; $display("FAIL rnd_valid c%0d got %0b want %0d", cyc, wr_valid, m_busy); end
      n_cmp++; if ({wr_addr, wr_data} !== {m_addr, m_data}) begin n_fail++; $display("FAIL rnd_write c%0d got %h/%h want %h/%h", cyc, wr_addr, wr_data, m_addr, m_data); end
      n_cmp++; if ({mr_tvalid, mr_qpn} !== {1'(m_mr), 4'(m_mrq)}) begin n_fail++; $display("FAIL rnd_mr c%0d got %0b/%0d want %0d/%0d", cyc, mr_tvalid, mr_qpn, m_mr, m_mrq); end
      n_cmp++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL rnd_pend c%0d got %h want %h", cyc, pend_mask, model_mask()); end
      n_cmp++; if ({drop_cnt, coal_cnt} !== {16'(m_drop), 16'(m_coal)}) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", cyc, drop_cnt, coal_cnt, m_drop, m_coal); end
    end
    rst = 1'b0; db_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_rr_order();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
